mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the fetch unit (read-only) and the load/store path (read/write).
- Sits between fetch_unit/d_mem and the physical memory interface. Needed once the core moves to a unified memory and multi-cycle or pipelined operation.
- Serialises accesses and gives data accesses priority, with a fairness guard so fetch is never starved.
- Detects and reports a memory that does not respond in time.

Parameters:
ADDR_W, `PC_SIZE, address width for both requesters and memory
DATA_W, 8, data word width
STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting
TIMEOUT, 16, cycles without mem_ack before abort

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch read request, held until if_ready
if_addr  in  ADDR_W  fetch address, stable while if_req
if_ready  out  1  one-cycle completion pulse to fetch
if_rdata  out  DATA_W  instruction byte, valid when if_ready
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = write, 0 = read; stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ready  out  1  one-cycle completion pulse to data path
d_rdata  out  DATA_W  load data, valid when d_ready; 0 for writes
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  one-cycle acknowledge; carries read data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset value of every output is 0. State resets to IDLE, starve_cnt to 0, timeout counter to 0.
- Reset asserted mid-transaction abandons the access: mem_req drops the next cycle and no ready pulse is issued.
- States:
  - IDLE: arbitrate. On a grant, register owner, we, addr and wdata into the mem_* output registers and go to BUSY. With no request, stay in IDLE.
  - BUSY: mem_req=1, with mem_we/addr/wdata held. mem_ack may arrive in the first BUSY cycle. On mem_ack, capture mem_rdata (or 0 for a write) into the owner's rdata register, drop mem_req and go to RESP.
  - RESP: the owner's ready is 1 for exactly this cycle; the other ready stays 0. Go to IDLE. Requests are not sampled in RESP.
- Requester rule: the requester deasserts req on the edge where it sees ready. A req still high in the following IDLE cycle is a new transaction.
- Latency: with a zero-wait memory, ready is high 2 cycles after req is first sampled in IDLE; each memory wait cycle adds 1. Throughput is at most one access per 3 cycles.
- Arbitration in IDLE:
  - d_req wins over if_req, except when starve_cnt == STARVE_MAX and if_req=1; then fetch wins.
  - starve_cnt increments on each data grant made while if_req=1, saturating at STARVE_MAX.
  - starve_cnt clears on any fetch grant, and on any data grant made while if_req=0.
- Timeout:
  - The BUSY counter starts at 0 on entry and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT-1 with no ack, set timeout_err=1 (sticky until rst), drop mem_req, return rdata=0 and go to RESP, so the requester still gets a ready pulse.
  - mem_ack in the same cycle as the counter reaching TIMEOUT-1 counts as success: no error is raised.
- mem_ack while not in BUSY is ignored.
- Outputs are registered; there is no combinational path from a req input to mem_req.

Decomposition:
- Shared package nand_cpu_pkg:
  - arb_state_t enum {IDLE, BUSY, RESP}
  - owner_t enum {OWN_IF, OWN_D}
  - DATA_W default constant
- The priority decision is a pure function in the package, arb_pick(if_req, d_req, starve_hit) -> owner_t, so the bench's scoreboard can reuse it.
- No sub-module; the timeout counter and starvation counter stay inline.

Test Plan:
- Single fetch, zero-wait memory: if_req=1, if_addr=0x10, mem_ack the first BUSY cycle with mem_rdata=0xA5 -> if_ready=1 with if_rdata=0xA5, 2 cycles after the request; mem_req high exactly 1 cycle.
- Write with 3 wait states: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x3C -> mem_we=1, mem_addr=0x20, mem_wdata=0x3C held 4 cycles; d_ready pulses once with d_rdata=0.
- Contention: if_req and d_req held continuously, STARVE_MAX=4 -> grant order D,D,D,D,IF,D,D,D,D,IF; no ready pulse ever goes to the non-owner.
- Timeout: d_req read, mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles; d_ready=1 with d_rdata=0; timeout_err=1 and stays 1 through a later successful fetch.
- Boundary ack: mem_ack asserted in BUSY cycle 16 -> normal completion with the data returned and timeout_err=0.
- Reset mid-BUSY: rst=1 in the second BUSY cycle -> all outputs 0 the next cycle, no ready pulse; a fresh if_req afterwards completes normally.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared types for the unified memory port arbiter.
// States, owner encoding, defaults and the priority pick.
package nand_cpu_pkg;

  localparam int PC_SIZE        = 16;
  localparam int DATA_W         = 8;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  // Data wins unless fetch has waited through the full
  // starvation budget and is still asking.
  function automatic owner_t arb_pick(
    input logic if_req,
    input logic d_req,
    input logic starve_hit
  );
    owner_t o;
    o = OWN_IF;
    if (if_req && starve_hit) begin
      o = OWN_IF;
    end else if (d_req) begin
      o = OWN_D;
    end
    return o;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch (read)
// and load/store (read/write); data first, fetch never starved.
// Ports: clk, rst (sync, high); if_req/if_addr -> if_ready/if_rdata;
// d_req/d_we/d_addr/d_wdata -> d_ready/d_rdata;
// mem_req/we/addr/wdata -> memory, mem_ack/mem_rdata <- memory;
// timeout_err is a sticky flag for a memory that never answered.
module mem_port_arbiter #(
  parameter int ADDR_W     = nand_cpu_pkg::PC_SIZE,
  parameter int DATA_W     = nand_cpu_pkg::DATA_W,
  parameter int STARVE_MAX = nand_cpu_pkg::STARVE_MAX_DEF,
  parameter int TIMEOUT    = nand_cpu_pkg::TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);
  import nand_cpu_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);
  localparam logic [TW-1:0] T_LST = TW'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic   starve_hit;
  owner_t pick;
  logic   done;
  logic [DATA_W-1:0] rdata_ret;

  assign starve_hit = (starve_q == S_MAX);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    pick        = arb_pick(if_req, d_req, starve_hit);
    done        = 1'b0;
    rdata_ret   = '0;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d   = pick;
          mem_req_d = 1'b1;
          tmo_d     = '0;
          state_d   = BUSY;
          if (pick == OWN_D) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Only data grants that bypass a waiting
            // fetch count toward starvation.
            if (!if_req) begin
              starve_d = '0;
            end else if (!starve_hit) begin
              starve_d = starve_q + SW'(1);
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end
        end
      end

      BUSY: begin
        // An ack on the last allowed cycle still wins.
        if (mem_ack) begin
          done      = 1'b1;
          rdata_ret = mem_we_q ? '0 : mem_rdata;
        end else if (tmo_q == T_LST) begin
          done  = 1'b1;
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
        if (done) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q == OWN_D) begin
            d_rdata_d = rdata_ret;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = rdata_ret;
            if_ready_d = 1'b1;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_ready    = if_ready_q;
  assign d_ready     = d_ready_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready),
    .d_rdata(d_rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory responder: wait mem_wait cycles (-1 never acks).
  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [256];
  int mem_wait = 0;
  bit mem_rand = 0;
  bit in_xfer = 0;
  int wcnt = 0;
  int cur_wait = 0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    if (mem_req) begin
      if (!in_xfer) begin
        in_xfer = 1'b1;
        wcnt = 0;
        cur_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (cur_wait >= 0 && wcnt == cur_wait) begin
        mem_ack = 1'b1;
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
        else mem_rdata = mem[mem_addr[7:0]];
      end else begin
        wcnt++;
      end
    end else begin
      in_xfer = 1'b0;
    end
  end

  // Request levels seen by the DUT at each edge.
  bit s_if = 0;
  bit s_d = 0;
  always @(posedge clk) begin
    s_if = if_req;
    s_d = d_req;
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    d_req = 1'b0;
    d_we = 1'b0;
    mem_wait = 0;
    mem_rand = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs until a ready pulse or the bound; counts BUSY cycles.
  task automatic wait_done(
    input  int            bound,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wd,
    output int            busy_n,
    output bit            got_if,
    output bit            got_d,
    output bit            fld_ok
  );
    busy_n = 0;
    got_if = 0;
    got_d = 0;
    fld_ok = 1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (if_ready || d_ready) begin
        got_if = if_ready;
        got_d = d_ready;
        break;
      end
      if (mem_req) begin
        busy_n++;
        if (mem_we !== e_we || mem_addr !== e_addr) fld_ok = 0;
        if (e_we && mem_wdata !== e_wd) fld_ok = 0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({if_ready, d_ready, mem_req, mem_we, timeout_err} !== 5'b0
        || if_rdata !== '0 || d_rdata !== '0
        || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b rdy=%b%b addr=%h want all 0",
               mem_req, if_ready, d_ready, mem_addr);
    end
    if_req = 1'b1;
    if_addr = 16'h0044;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: mem_req=%b want 0", mem_req);
    end
    if_req = 1'b0;
  endtask

  task automatic test_single_fetch();
    apply_reset();
    mem[8'h10] = 8'hA5;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 16'h0010;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0010
        || mem_we !== 1'b0 || if_ready !== 1'b0) begin
      bad++;
      $display("FAIL fetch_busy: req=%b addr=%h we=%b rdy=%b want 1 0010 0 0",
               mem_req, mem_addr, mem_we, if_ready);
    end
    @(negedge clk);
    total++;
    if (if_ready !== 1'b1 || if_rdata !== 8'hA5
        || mem_req !== 1'b0 || d_ready !== 1'b0) begin
      bad++;
      $display("FAIL fetch_resp: rdy=%b data=%h req=%b drdy=%b want 1 a5 0 0",
               if_ready, if_rdata, mem_req, d_ready);
    end
    if_req = 1'b0;
    @(negedge clk);
    total++;
    if (if_ready !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_pulse: rdy=%b req=%b want 0 0", if_ready, mem_req);
    end
  endtask

  task automatic test_write_wait();
    int n;
    bit gi, gd, ok;
    apply_reset();
    mem_wait = 3;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 16'h0020;
    d_wdata = 8'h3C;
    wait_done(40, 1'b1, 16'h0020, 8'h3C, n, gi, gd, ok);
    total++;
    if (n != 4 || !ok) begin
      bad++;
      $display("FAIL write_busy: cycles=%0d fields_ok=%0d want 4 1", n, ok);
    end
    total++;
    if (!gd || gi || d_rdata !== 8'h00) begin
      bad++;
      $display("FAIL write_resp: drdy=%0d irdy=%0d data=%h want 1 0 00",
               gd, gi, d_rdata);
    end
    d_req = 1'b0;
    d_we = 1'b0;
    @(negedge clk);
    total++;
    if (d_ready !== 1'b0) begin
      bad++;
      $display("FAIL write_pulse: d_ready=%b want 0", d_ready);
    end
  endtask

  task automatic test_contention();
    int seq_got[$];
    int exp_own;
    int cnt;
    bit both;
    apply_reset();
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 16'h0040;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 16'h0050;
    both = 0;
    for (int c = 0; c < 80 && seq_got.size() < 10; c++) begin
      @(negedge clk);
      if (if_ready && d_ready) both = 1;
      else if (d_ready) seq_got.push_back(1);
      else if (if_ready) seq_got.push_back(0);
    end
    if_req = 1'b0;
    d_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (cnt == SMAX) begin
        exp_own = 0;
        cnt = 0;
      end else begin
        exp_own = 1;
        cnt++;
      end
      total++;
      if (k >= seq_got.size()) begin
        bad++;
        $display("FAIL contend_%0d: no grant seen want %0d", k, exp_own);
      end else if (seq_got[k] != exp_own) begin
        bad++;
        $display("FAIL contend_%0d: owner=%0d want %0d (1=D)",
                 k, seq_got[k], exp_own);
      end
    end
    total++;
    if (both) begin
      bad++;
      $display("FAIL contend_both: both readies high want one");
    end
  endtask

  task automatic test_boundary_ack();
    int n;
    bit gi, gd, ok;
    apply_reset();
    mem[8'h31] = 8'hC3;
    mem_wait = TMO - 1;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 16'h0031;
    wait_done(40, 1'b0, 16'h0031, 8'h00, n, gi, gd, ok);
    total++;
    if (n != TMO || !gd || d_rdata !== 8'hC3) begin
      bad++;
      $display("FAIL boundary_ack: cycles=%0d drdy=%0d data=%h want %0d 1 c3",
               n, gd, d_rdata, TMO);
    end
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL boundary_err: timeout_err=%b want 0", timeout_err);
    end
    d_req = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    bit gi, gd, ok;
    apply_reset();
    mem_wait = -1;
    @(negedge clk);
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 16'h0030;
    wait_done(40, 1'b0, 16'h0030, 8'h00, n, gi, gd, ok);
    total++;
    if (n != TMO || !ok) begin
      bad++;
      $display("FAIL timeout_busy: cycles=%0d want %0d", n, TMO);
    end
    total++;
    if (!gd || gi || d_rdata !== 8'h00 || timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_resp: drdy=%0d data=%h err=%b want 1 00 1",
               gd, d_rdata, timeout_err);
    end
    d_req = 1'b0;
    mem_wait = 0;
    mem[8'h11] = 8'h5A;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 16'h0011;
    wait_done(20, 1'b0, 16'h0011, 8'h00, n, gi, gd, ok);
    total++;
    if (!gi || if_rdata !== 8'h5A || n != 1) begin
      bad++;
      $display("FAIL timeout_after: irdy=%0d data=%h cycles=%0d want 1 5a 1",
               gi, if_rdata, n);
    end
    total++;
    if (timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_sticky: timeout_err=%b want 1", timeout_err);
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int n;
    bit gi, gd, ok;
    bit seen;
    apply_reset();
    mem_wait = 5;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 16'h0012;
    @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy: mem_req=%b want 1", mem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_req, mem_we, if_ready, d_ready} !== 4'b0
        || mem_addr !== '0 || if_rdata !== '0) begin
      bad++;
      $display("FAIL rstmid_out: req=%b addr=%h rdy=%b want 0 0000 0",
               mem_req, mem_addr, if_ready);
    end
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_ready || d_ready || mem_req) seen = 1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL rstmid_quiet: activity after reset want none");
    end
    mem_wait = 0;
    mem[8'h12] = 8'h77;
    if_req = 1'b1;
    wait_done(20, 1'b0, 16'h0012, 8'h00, n, gi, gd, ok);
    total++;
    if (!gi || if_rdata !== 8'h77 || !ok) begin
      bad++;
      $display("FAIL rstmid_fresh: irdy=%0d data=%h want 1 77", gi, if_rdata);
    end
    if_req = 1'b0;
  endtask

  // Transaction-level reference: grant order from pending
  // requests and a count of data grants bypassing fetch.
  task automatic test_random();
    bit if_done, d_done;
    logic [DW-1:0] exp_if, exp_d;
    int m_starve;
    apply_reset();
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem_rand = 1;
    if_done = 0;
    d_done = 0;
    exp_if = '0;
    exp_d = '0;
    m_starve = 0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          bit got;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          if_addr = AW'($urandom_range(0, 255));
          if_req = 1'b1;
          got = 0;
          for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (if_ready) got = 1;
          end
          total++;
          if (!got) begin
            bad++;
            $display("FAIL rnd_if_hang: tx %0d no ready", k);
          end else if (if_rdata !== exp_if) begin
            bad++;
            $display("FAIL rnd_if_data: tx %0d got %h want %h",
                     k, if_rdata, exp_if);
          end
          if_req = 1'b0;
        end
        if_done = 1;
      end
      begin
        for (int k = 0; k < 30; k++) begin
          bit got;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          d_addr = AW'($urandom_range(0, 255));
          d_we = 1'($urandom);
          d_wdata = DW'($urandom);
          d_req = 1'b1;
          got = 0;
          for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (d_ready) got = 1;
          end
          total++;
          if (!got) begin
            bad++;
            $display("FAIL rnd_d_hang: tx %0d no ready", k);
          end else if (d_rdata !== exp_d) begin
            bad++;
            $display("FAIL rnd_d_data: tx %0d got %h want %h",
                     k, d_rdata, exp_d);
          end
          d_req = 1'b0;
        end
        d_done = 1;
      end
      begin
        bit prev;
        bit want_d;
        bit ok;
        prev = 0;
        for (int c = 0; c < 4000 && !(if_done && d_done); c++) begin
          @(negedge clk);
          if (mem_req && !prev) begin
            want_d = s_d && !(m_starve == SMAX && s_if);
            if (want_d) begin
              ok = (mem_we === d_we) && (mem_addr === d_addr);
              if (d_we && mem_wdata !== d_wdata) ok = 0;
              m_starve = s_if ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
              if (d_we) begin
                ref_mem[d_addr[7:0]] = d_wdata;
                exp_d = '0;
              end else begin
                exp_d = ref_mem[d_addr[7:0]];
              end
            end else begin
              ok = (mem_we === 1'b0) && (mem_addr === if_addr);
              m_starve = 0;
              exp_if = ref_mem[if_addr[7:0]];
            end
            total++;
            if (!ok) begin
              bad++;
              $display("FAIL rnd_grant: we=%b addr=%h want owner %s",
                       mem_we, mem_addr, want_d ? "D" : "IF");
            end
          end
          if (if_ready && d_ready) begin
            total++;
            bad++;
            $display("FAIL rnd_both: both readies high want one");
          end
          prev = mem_req;
        end
        total++;
        if (!(if_done && d_done)) begin
          bad++;
          $display("FAIL rnd_budget: if_done=%0d d_done=%0d want 1 1",
                   if_done, d_done);
        end
      end
    join_any
    disable fork;
    if_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_write_wait();
    test_contention();
    test_boundary_ack();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
